ex_sim: RTL and testbench

EX_SIM -- requirements
Module: ex_sim

---
 rtl/ex_sim_pkg.sv | 35 +++
 rtl/ex_sim.sv | 108 ++++++++++
 tb/tb_ex_sim.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_sim_pkg.sv
// Shared types and constants for the ex_sim UDP packet generator.
// Packet type codes, payload fill words, header geometry and FSM state encoding.
package ex_sim_pkg;

    typedef enum logic [7:0] {
        PKT_ACK  = 8'd1,
        PKT_NACK = 8'd2,
        PKT_DATA = 8'd3
    } pkt_type_t;

    localparam logic [63:0] FILL_BEAT1 = 64'h0F0F0F0F0F0F0F0F;
    localparam logic [63:0] FILL_BEAT2 = 64'h0101010101010101;

    localparam int          HDR_WIDTH  = 112;
    localparam logic [15:0] PKT_LENGTH = 16'd24;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_PLD0 = 3'd2;
    localparam state_t ST_PLD1 = 3'd3;
    localparam state_t ST_PLD2 = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    // Network order puts the most significant byte first, i.e. in the lowest lane.
    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/ex_sim.sv
// Simulated UDP source: emits NUM_PKTS packets of one header plus three payload beats.
// Define EX_SIM_LOOP_EN to keep generating packets forever instead of stopping in DONE.
module ex_sim
    import ex_sim_pkg::*;
#(
    parameter logic [31:0] SRC_IP    = 32'hC0A80181,
    parameter logic [31:0] DST_IP    = 32'hC0A80180,
    parameter logic [15:0] SRC_PORT  = 16'd1000,
    parameter logic [15:0] DST_PORT  = 16'd1234,
    parameter int          NUM_PKTS  = 9,
    parameter logic [31:0] SEQ_START = 32'd1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    output logic [HDR_WIDTH-1:0] M_AXIS_hdr_tdata,
    output logic                 M_AXIS_hdr_tvalid,
    input  logic                 M_AXIS_hdr_tready,
    output logic [63:0]          M_AXIS_payload_tdata,
    output logic [7:0]           M_AXIS_payload_tkeep,
    output logic                 M_AXIS_payload_tlast,
    output logic                 M_AXIS_payload_tvalid,
    input  logic                 M_AXIS_payload_tready
);

    localparam logic [HDR_WIDTH-1:0] HDR_WORD = {
        bswap16(PKT_LENGTH), bswap16(DST_PORT), bswap16(SRC_PORT),
        bswap32(DST_IP), bswap32(SRC_IP)
    };

    state_t      state;
    logic [1:0]  idle_cnt;
    logic [31:0] seq_num;
`ifndef EX_SIM_LOOP_EN
    logic [31:0] pkt_cnt;
`endif

    // Outputs decode straight from state, so they hold steady until the handshake moves it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            idle_cnt <= 2'd0;
            seq_num  <= SEQ_START;
`ifndef EX_SIM_LOOP_EN
            pkt_cnt  <= 32'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_cnt == 2'd3) state <= ST_HDR;
                    else                  idle_cnt <= idle_cnt + 2'd1;
                end
                ST_HDR:  if (M_AXIS_hdr_tready)     state <= ST_PLD0;
                ST_PLD0: if (M_AXIS_payload_tready) state <= ST_PLD1;
                ST_PLD1: if (M_AXIS_payload_tready) state <= ST_PLD2;
                ST_PLD2: begin
                    if (M_AXIS_payload_tready) begin
                        seq_num <= seq_num + 32'd1;
`ifdef EX_SIM_LOOP_EN
                        state   <= ST_HDR;
`else
                        if (pkt_cnt == 32'(NUM_PKTS - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            state   <= ST_HDR;
                            pkt_cnt <= pkt_cnt + 32'd1;
                        end
`endif
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        M_AXIS_hdr_tdata      = '0;
        M_AXIS_hdr_tvalid     = 1'b0;
        M_AXIS_payload_tdata  = 64'd0;
        M_AXIS_payload_tkeep  = 8'h00;
        M_AXIS_payload_tlast  = 1'b0;
        M_AXIS_payload_tvalid = 1'b0;
        case (state)
            ST_HDR: begin
                M_AXIS_hdr_tdata  = HDR_WORD;
                M_AXIS_hdr_tvalid = 1'b1;
            end
            ST_PLD0: begin
                M_AXIS_payload_tdata  = {24'd0, bswap32(seq_num), PKT_DATA};
                M_AXIS_payload_tkeep  = 8'hFF;
                M_AXIS_payload_tvalid = 1'b1;
            end
            ST_PLD1: begin
                M_AXIS_payload_tdata  = FILL_BEAT1;
                M_AXIS_payload_tkeep  = 8'hFF;
                M_AXIS_payload_tvalid = 1'b1;
            end
            ST_PLD2: begin
                M_AXIS_payload_tdata  = FILL_BEAT2;
                M_AXIS_payload_tkeep  = 8'hFF;
                M_AXIS_payload_tlast  = 1'b1;
                M_AXIS_payload_tvalid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ex_sim.sv
// Self-checking bench for ex_sim: vector table, directed corner sequences and random readys
// checked against a transfer-level packet model. Honours EX_SIM_LOOP_EN when defined.
module tb_ex_sim;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [111:0] hdr_tdata;
    logic         hdr_tvalid;
    logic         hdr_tready;
    logic [63:0]  pld_tdata;
    logic [7:0]   pld_tkeep;
    logic         pld_tlast;
    logic         pld_tvalid;
    logic         pld_tready;

    int errors = 0;
    int checks = 0;

    // Packet model state: position in packet (0 = header next), next sequence, finished packets.
    int          exp_pos = 0;
    logic [31:0] exp_seq = 32'd1;
    int          pkts    = 0;

    // 192.168.1.129 / 192.168.1.128 / 1000 / 1234 / 24, each field byte-swapped.
    localparam logic [111:0] HDR_EXP = {16'h1800, 16'hD204, 16'hE803, 32'h8001A8C0, 32'h8101A8C0};

    typedef struct {
        logic        hdr_rdy;
        logic        pld_rdy;
        logic        exp_hv;
        logic        exp_pv;
        logic        exp_last;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    always #5 aclk = ~aclk;

    ex_sim dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .M_AXIS_hdr_tdata      (hdr_tdata),
        .M_AXIS_hdr_tvalid     (hdr_tvalid),
        .M_AXIS_hdr_tready     (hdr_tready),
        .M_AXIS_payload_tdata  (pld_tdata),
        .M_AXIS_payload_tkeep  (pld_tkeep),
        .M_AXIS_payload_tlast  (pld_tlast),
        .M_AXIS_payload_tvalid (pld_tvalid),
        .M_AXIS_payload_tready (pld_tready)
    );

    function automatic logic [63:0] beat0Exp(input logic [31:0] s);
        return {24'h0, s[7:0], s[15:8], s[23:16], s[31:24], 8'h03};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic p);
        @(posedge aclk);
        #1;
        hdr_tready = h;
        pld_tready = p;
    endtask

    task automatic doReset();
        aresetn    = 1'b0;
        hdr_tready = 1'b0;
        pld_tready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #2;
        aresetn = 1'b1;
    endtask

    task automatic waitPkts(input string name, input int n, input int budget);
        int c = 0;
        while (pkts < n && c < budget) begin
            @(posedge aclk);
            #1;
            c++;
        end
        checkOutput(name, 128'(pkts >= n), 128'(1));
    endtask

    // Watches every negedge: tracks accepted transfers and checks them against packet rules.
    task automatic monitor();
        logic [111:0] held_hdr;
        logic [63:0]  held_pld;
        logic [7:0]   held_keep;
        logic         held_last;
        logic         hdr_pend = 1'b0;
        logic         pld_pend = 1'b0;
        logic [63:0]  exp_d;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                exp_pos  = 0;
                exp_seq  = 32'd1;
                pkts     = 0;
                hdr_pend = 1'b0;
                pld_pend = 1'b0;
                checkOutput("reset_pld", 128'({hdr_tvalid, pld_tvalid, pld_tlast, pld_tkeep, pld_tdata}), 128'(0));
                checkOutput("reset_hdr", 128'(hdr_tdata), 128'(0));
            end else begin
                checkOutput("valid_exclusive", 128'(hdr_tvalid & pld_tvalid), 128'(0));
                if (hdr_pend)
                    checkOutput("hdr_hold", 128'({hdr_tvalid, hdr_tdata}), 128'({1'b1, held_hdr}));
                if (pld_pend)
                    checkOutput("pld_hold", 128'({pld_tvalid, pld_tdata, pld_tkeep, pld_tlast}),
                                128'({1'b1, held_pld, held_keep, held_last}));
`ifndef EX_SIM_LOOP_EN
                if (pkts >= 9)
                    checkOutput("after_done", 128'({hdr_tvalid, pld_tvalid}), 128'(0));
`endif
                if (hdr_tvalid && hdr_tready) begin
                    checkOutput("hdr_order", 128'(exp_pos), 128'(0));
                    checkOutput("hdr_data", 128'(hdr_tdata), 128'(HDR_EXP));
                    exp_pos = 1;
                end
                if (pld_tvalid && pld_tready) begin
                    checkOutput("pld_order", 128'(exp_pos != 0), 128'(1));
                    case (exp_pos)
                        1:       exp_d = beat0Exp(exp_seq);
                        2:       exp_d = 64'h0F0F0F0F0F0F0F0F;
                        default: exp_d = 64'h0101010101010101;
                    endcase
                    checkOutput("pld_beat", 128'({pld_tdata, pld_tkeep, pld_tlast}),
                                128'({exp_d, 8'hFF, exp_pos == 3}));
                    if (exp_pos == 3) begin
                        exp_pos = 0;
                        exp_seq = exp_seq + 32'd1;
                        pkts++;
                    end else if (exp_pos != 0) begin
                        exp_pos++;
                    end
                end
                hdr_pend  = hdr_tvalid && !hdr_tready;
                pld_pend  = pld_tvalid && !pld_tready;
                held_hdr  = hdr_tdata;
                held_pld  = pld_tdata;
                held_keep = pld_tkeep;
                held_last = pld_tlast;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0000000100000003};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0000000100000003};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0F0F0F0F0F0F0F0F};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0101010101010101};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0};

        aresetn    = 1'b0;
        hdr_tready = 1'b0;
        pld_tready = 1'b0;
        fork
            monitor();
        join_none

        // Phase 1: vector table over the first packet, then free-running to the end of the run.
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].hdr_rdy, vecs[i].pld_rdy);
            @(negedge aclk);
            checkOutput($sformatf("vec%0d_ctrl", i), 128'({hdr_tvalid, pld_tvalid, pld_tlast}),
                        128'({vecs[i].exp_hv, vecs[i].exp_pv, vecs[i].exp_last}));
            if (vecs[i].exp_pv)
                checkOutput($sformatf("vec%0d_data", i), 128'({pld_tdata, pld_tkeep}),
                            128'({vecs[i].exp_data, 8'hFF}));
            if (vecs[i].exp_hv)
                checkOutput($sformatf("vec%0d_hdr", i), 128'(hdr_tdata), 128'(HDR_EXP));
        end
        hdr_tready = 1'b1;
        pld_tready = 1'b1;
`ifdef EX_SIM_LOOP_EN
        waitPkts("loop_pkt10", 10, 300);
`else
        waitPkts("run_9_pkts", 9, 300);
        repeat (20) @(posedge aclk);
        #1;
        checkOutput("done_pkt_count", 128'(pkts), 128'(9));
        checkOutput("done_quiet", 128'({hdr_tvalid, pld_tvalid}), 128'(0));
`endif

        // Phase 2: payload ready toggling every cycle, then fully random readys.
        doReset();
        for (int i = 0; i < 400; i++) begin
            @(posedge aclk);
            #1;
            hdr_tready = 1'($urandom_range(0, 1));
            pld_tready = (i < 60) ? i[0] : 1'($urandom_range(0, 1));
        end
        hdr_tready = 1'b1;
        pld_tready = 1'b1;
        waitPkts("random_9_pkts", 9, 300);

        // Phase 3: header stalled for 10 cycles with payload ready high.
        doReset();
        pld_tready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge aclk);
            #1;
            found = hdr_tvalid;
        end
        checkOutput("hdr_stall_start", 128'(found), 128'(1));
        for (int c = 0; c < 10; c++) begin
            @(posedge aclk);
            #1;
            checkOutput("hdr_stall", 128'({hdr_tvalid, pld_tvalid}), 128'(2'b10));
        end
        hdr_tready = 1'b1;

        // Phase 4: reset pulsed during beat 1 of packet 3, then restart from sequence 1.
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge aclk);
            #1;
            found = (pkts == 2) && (exp_pos == 2) && pld_tvalid;
        end
        checkOutput("reach_pkt3_beat1", 128'(found), 128'(1));
        aresetn = 1'b0;
        #1;
        checkOutput("reset_async", 128'({hdr_tvalid, pld_tvalid, pld_tlast, pld_tkeep, pld_tdata}), 128'(0));
        repeat (2) @(negedge aclk);
        #2;
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk);
            #2;
            checkOutput($sformatf("restart_idle%0d", i), 128'({hdr_tvalid, pld_tvalid}),
                        128'((i < 3) ? 2'b00 : 2'b10));
        end
        waitPkts("restart_pkt1", 1, 50);
        checkOutput("restart_seq", 128'(exp_seq), 128'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
